// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot job scheduler.
// Coordinates are two's complement Q4.28.
package mandel_pkg;

  localparam int unsigned COORD_W     = 32;
  localparam int unsigned COLOUR_W    = 9;
  localparam int unsigned Q_FRAC_BITS = 28;

  localparam logic [COORD_W-1:0] IM_MAX_DEF  = COORD_W'(1) << Q_FRAC_BITS;
  localparam logic [COORD_W-1:0] RE_MIN_DEF  = ~(IM_MAX_DEF << 1) + COORD_W'(1);
  localparam logic [COORD_W-1:0] RE_STEP_DEF = 32'h0180_0000;
  localparam logic [COORD_W-1:0] IM_STEP_DEF = 32'h0155_5555;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the priority pointer.
// The pointer moves just past the granted index when the grant is accepted.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx, next_ptr;
  logic            found;

  function automatic logic [PtrW-1:0] wrap_idx(logic [PtrW-1:0] base, int unsigned off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return PtrW'(s);
  endfunction

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    idx      = '0;
    next_ptr = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = wrap_idx(ptr_q, k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = wrap_idx(idx, 1);
      end
    end
    ptr_d = accept ? next_ptr : ptr_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mandel_job_scheduler.sv
// Frame scheduler: walks every pixel, dispatches (re, im) jobs to free calculator cores
// and serialises their colour results onto a single framebuffer write port.
module mandel_job_scheduler
  import mandel_pkg::*;
#(
  parameter int unsigned         H_ACTIVE  = 32,
  parameter int unsigned         V_ACTIVE  = 24,
  parameter int unsigned         NUM_CORES = 4,
  parameter logic [COORD_W-1:0]  RE_MIN    = RE_MIN_DEF,
  parameter logic [COORD_W-1:0]  IM_MAX    = IM_MAX_DEF,
  parameter logic [COORD_W-1:0]  RE_STEP   = RE_STEP_DEF,
  parameter logic [COORD_W-1:0]  IM_STEP   = IM_STEP_DEF,
  localparam int unsigned        AddrW     = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            frame_start,
  input  logic [NUM_CORES-1:0]            core_ready,
  output logic [NUM_CORES-1:0]            core_start,
  output logic [COORD_W-1:0]              core_re,
  output logic [COORD_W-1:0]              core_im,
  input  logic [NUM_CORES-1:0]            core_done,
  input  logic [NUM_CORES*COLOUR_W-1:0]   core_colour,
  output logic                            fb_we,
  output logic [AddrW-1:0]                fb_addr,
  output logic [COLOUR_W-1:0]             fb_data,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int unsigned NumPix = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CntW   = $clog2(NumPix + 1);
  localparam int unsigned XW     = $clog2(H_ACTIVE);

  sched_state_e state_q, state_d;

  logic [XW-1:0]      x_q, x_d;
  logic [COORD_W-1:0] re_q, re_d, im_q, im_d;
  logic [AddrW-1:0]   disp_cnt_q, disp_cnt_d;
  logic [CntW-1:0]    wr_cnt_q, wr_cnt_d;

  logic [NUM_CORES-1:0]                in_flight_q, in_flight_d;
  logic [NUM_CORES-1:0]                pending_q, pending_d;
  logic [NUM_CORES-1:0][AddrW-1:0]     tag_q, tag_d;
  logic [NUM_CORES-1:0][COLOUR_W-1:0]  colour_q, colour_d;

  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [COORD_W-1:0]   core_re_q, core_re_d, core_im_q, core_im_d;
  logic                 fb_we_q, fb_we_d;
  logic [AddrW-1:0]     fb_addr_q, fb_addr_d;
  logic [COLOUR_W-1:0]  fb_data_q, fb_data_d;

  logic [NUM_CORES-1:0] disp_req, disp_gnt, wb_gnt;
  logic                 disp_accept, wb_accept;

  // A core is only eligible once its previous result has left through the write port.
  assign disp_req    = (state_q == StIssue) ? (core_ready & ~pending_q & ~in_flight_q) : '0;
  assign disp_accept = |disp_gnt;
  assign wb_accept   = |wb_gnt;

  rr_arbiter #(
    .N(NUM_CORES)
  ) u_disp_arb (
    .clk_in (clk_in),
    .reset  (reset),
    .req    (disp_req),
    .accept (disp_accept),
    .grant  (disp_gnt)
  );

  rr_arbiter #(
    .N(NUM_CORES)
  ) u_wb_arb (
    .clk_in (clk_in),
    .reset  (reset),
    .req    (pending_q),
    .accept (wb_accept),
    .grant  (wb_gnt)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    re_d         = re_q;
    im_d         = im_q;
    disp_cnt_d   = disp_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    in_flight_d  = in_flight_q;
    pending_d    = pending_q;
    tag_d        = tag_q;
    colour_d     = colour_q;
    core_start_d = '0;
    core_re_d    = core_re_q;
    core_im_d    = core_im_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;

    // Results from cores with no job in flight are stale and dropped.
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (core_done[i] && in_flight_q[i]) begin
        in_flight_d[i] = 1'b0;
        pending_d[i]   = 1'b1;
        colour_d[i]    = core_colour[i*COLOUR_W +: COLOUR_W];
      end
      if (disp_gnt[i]) begin
        in_flight_d[i] = 1'b1;
        tag_d[i]       = disp_cnt_q;
      end
      if (wb_gnt[i]) begin
        pending_d[i] = 1'b0;
        fb_addr_d    = tag_q[i];
        fb_data_d    = colour_q[i];
      end
    end

    if (wb_accept) begin
      fb_we_d  = 1'b1;
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d    = StIssue;
          x_d        = '0;
          re_d       = RE_MIN;
          im_d       = IM_MAX;
          disp_cnt_d = '0;
          wr_cnt_d   = '0;
        end
      end
      StIssue: begin
        if (disp_accept) begin
          core_start_d = disp_gnt;
          core_re_d    = re_q;
          core_im_d    = im_q;
          disp_cnt_d   = disp_cnt_q + 1'b1;
          if (x_q == XW'(H_ACTIVE - 1)) begin
            x_d  = '0;
            re_d = RE_MIN;
            im_d = im_q - IM_STEP;
          end else begin
            x_d  = x_q + 1'b1;
            re_d = re_q + RE_STEP;
          end
          if (disp_cnt_q == AddrW'(NumPix - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (wr_cnt_q == CntW'(NumPix)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= StIdle;
      x_q          <= '0;
      re_q         <= RE_MIN;
      im_q         <= IM_MAX;
      disp_cnt_q   <= '0;
      wr_cnt_q     <= '0;
      in_flight_q  <= '0;
      pending_q    <= '0;
      tag_q        <= '0;
      colour_q     <= '0;
      core_start_q <= '0;
      core_re_q    <= '0;
      core_im_q    <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      re_q         <= re_d;
      im_q         <= im_d;
      disp_cnt_q   <= disp_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      in_flight_q  <= in_flight_d;
      pending_q    <= pending_d;
      tag_q        <= tag_d;
      colour_q     <= colour_d;
      core_start_q <= core_start_d;
      core_re_q    <= core_re_d;
      core_im_q    <= core_im_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
    end
  end

  assign core_start = core_start_q;
  assign core_re    = core_re_q;
  assign core_im    = core_im_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_mandel_job_scheduler.sv
// Directed bench for mandel_job_scheduler with a behavioural model of four calculator cores.
module tb_mandel_job_scheduler;

  localparam int NPIX = 768;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [3:0]  core_ready = '0;
  logic [3:0]  core_start;
  logic [31:0] core_re, core_im;
  logic [3:0]  core_done = '0;
  logic [35:0] core_colour = '0;
  logic        fb_we;
  logic [9:0]  fb_addr;
  logic [8:0]  fb_data;
  logic        busy, frame_done;

  mandel_job_scheduler #(
    .NUM_CORES(4)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .frame_start (frame_start),
    .core_ready  (core_ready),
    .core_start  (core_start),
    .core_re     (core_re),
    .core_im     (core_im),
    .core_done   (core_done),
    .core_colour (core_colour),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass = 0;

  bit written[1024];
  int wr_count, done_cnt, disp_idx, next_addr;
  bit check_order;

  int          cnt[4];
  bit          cbusy[4];
  logic [31:0] jre[4], jim[4];
  bit          en[4];
  bit          hold;
  int          fixed_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] colour_of(input logic [31:0] re, input logic [31:0] im);
    return re[31:23] ^ {im[27:23], im[31:28]};
  endfunction

  function automatic logic [8:0] exp_colour(input int addr);
    logic [31:0] re, im;
    re = 32'hE000_0000 + 32'(addr % 32) * 32'h0180_0000;
    im = 32'h1000_0000 - 32'(addr / 32) * 32'h0155_5555;
    return colour_of(re, im);
  endfunction

  // One clock: sample DUT outputs at the falling edge, then advance the core model.
  task automatic tick();
    @(negedge clk_in);
    if (fb_we) begin
      chk("wr_dup", 64'(written[fb_addr]), 0);
      chk("wr_data", fb_data, exp_colour(int'(fb_addr)));
      if (check_order) chk("wr_order", fb_addr, next_addr);
      written[fb_addr] = 1'b1;
      wr_count++;
      next_addr++;
    end
    if (frame_done) begin
      done_cnt++;
      chk("done_wr_count", wr_count, NPIX);
      chk("busy_in_done", busy, 1);
    end
    if (core_start != '0) begin
      chk("start_onehot", 64'($onehot(core_start)), 1);
      if (disp_idx == 31) begin
        chk("re_x31_y0", core_re, 32'h0E80_0000);
        chk("im_x31_y0", core_im, 32'h1000_0000);
      end
      if (disp_idx == 32) begin
        chk("re_x0_y1", core_re, 32'hE000_0000);
        chk("im_x0_y1", core_im, 32'h0EAA_AAAB);
      end
      disp_idx++;
    end
    core_done = '0;
    for (int i = 0; i < 4; i++) begin
      if (cbusy[i]) begin
        if (cnt[i] > 0) cnt[i]--;
        if (cnt[i] == 0 && !hold) begin
          core_done[i] = 1'b1;
          core_colour[i*9 +: 9] = colour_of(jre[i], jim[i]);
          cbusy[i] = 1'b0;
        end
      end
      if (core_start[i]) begin
        cbusy[i] = 1'b1;
        jre[i]   = core_re;
        jim[i]   = core_im;
        cnt[i]   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(20, 1));
      end
      core_ready[i] = en[i] & ~cbusy[i];
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_re"}, core_re, 0);
    chk({tag, "_core_im"}, core_im, 0);
    chk({tag, "_fb_we"}, fb_we, 0);
    chk({tag, "_fb_addr"}, fb_addr, 0);
    chk({tag, "_fb_data"}, fb_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic start_frame();
    foreach (written[a]) written[a] = 1'b0;
    wr_count  = 0;
    done_cnt  = 0;
    disp_idx  = 0;
    next_addr = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_start_yet", core_start, 0);
  endtask

  task automatic finish_frame(input int budget);
    int n;
    for (int c = 0; c < budget && done_cnt == 0; c++) tick();
    chk("frame_done_seen", done_cnt, 1);
    chk("total_writes", wr_count, NPIX);
    n = 0;
    foreach (written[a]) if (written[a]) n++;
    chk("addr_coverage", n, NPIX);
    tick();
    chk("busy_dropped", busy, 0);
    repeat (3) tick();
    chk("frame_done_once", done_cnt, 1);
  endtask

  initial begin
    hold = 1'b0;
    fixed_lat = 2;
    check_order = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0;
      cbusy[i] = 1'b0;
      cnt[i] = 0;
    end

    // Reset state
    repeat (3) tick();
    check_zero("rst");
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // One core, fixed 2-cycle latency, in-order writes; stray frame_start mid-frame
    en[0] = 1'b1;
    start_frame();
    tick();
    chk("first_start", core_start, 4'b0001);
    chk("first_re", core_re, 32'hE000_0000);
    chk("first_im", core_im, 32'h1000_0000);
    repeat (300) tick();
    chk("busy_mid", busy, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    finish_frame(20000);

    // Four cores, random latency 1..20
    for (int i = 0; i < 4; i++) en[i] = 1'b1;
    fixed_lat = 0;
    check_order = 1'b0;
    start_frame();
    finish_frame(20000);

    // Four simultaneous results after reset: written in core order 0..3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fixed_lat = 1;
    hold = 1'b1;
    start_frame();
    repeat (6) tick();
    chk("held_no_we", fb_we, 0);
    hold = 1'b0;
    tick();
    tick();
    chk("capture_no_we", fb_we, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("burst_we", fb_we, 1);
      chk("burst_addr", fb_addr, k);
    end
    finish_frame(20000);

    // Reset after 100 writes, then a clean frame
    fixed_lat = 0;
    start_frame();
    for (int c = 0; c < 5000 && wr_count < 100; c++) tick();
    chk("reached_100", wr_count, 100);
    reset = 1'b1;
    tick();
    check_zero("mid_rst");
    tick();
    reset = 1'b0;
    repeat (25) begin
      tick();
      chk("no_we_after_rst", fb_we, 0);
    end
    start_frame();
    finish_frame(20000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
